// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry decoder: key codes, FSM encoding and
// the active-low one-hot helpers used on the scanner code.
package keypad_pkg;

  localparam int unsigned CNT_W = 16;

  localparam logic [3:0] KEY_BKSP = 4'hA;
  localparam logic [3:0] KEY_CLR  = 4'hB;
  localparam logic [3:0] KEY_ENT  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DECODE   = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_e;

  // Position of the single low bit; illegal patterns map to 0 and are
  // rejected separately by onehot_n_ok.
  function automatic logic [1:0] onehot_n_to_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic onehot_n_ok(input logic [3:0] v);
    return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
  endfunction

endpackage

// File: rtl/keypad_entry_decoder_if.sv
// Scanner-to-decoder link: encoded key event in, decoded key and entry out.
interface keypad_entry_decoder_if #(
  parameter int unsigned DIGITS = 4
);
  logic [7:0]          enc_in;
  logic                pressed_in;
  logic                key_valid;
  logic [3:0]          key_code;
  logic                key_err;
  logic [4*DIGITS-1:0] entry_bcd;
  logic [3:0]          entry_count;
  logic                entry_valid;
  logic [4*DIGITS-1:0] entry_value;
  logic                overflow;

  modport master (
    output enc_in, pressed_in,
    input  key_valid, key_code, key_err, entry_bcd, entry_count,
           entry_valid, entry_value, overflow
  );

  modport slave (
    input  enc_in, pressed_in,
    output key_valid, key_code, key_err, entry_bcd, entry_count,
           entry_valid, entry_value, overflow
  );
endinterface

// File: rtl/keypad_entry_buffer.sv
// BCD entry accumulator: digit shift-in, backspace, clear and enter snapshot,
// driven by one decoded key per key_valid_i.
module keypad_entry_buffer
  import keypad_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid_i,
  input  logic [3:0]          key_code_i,
  output logic [4*DIGITS-1:0] entry_bcd,
  output logic [3:0]          entry_count,
  output logic                entry_valid,
  output logic [4*DIGITS-1:0] entry_value,
  output logic                overflow
);

  localparam int unsigned W = 4 * DIGITS;
  localparam logic [3:0] FULL = 4'(DIGITS);

  logic [W-1:0] bcd_q, bcd_d;
  logic [W-1:0] value_q, value_d;
  logic [3:0]   count_q, count_d;
  logic         valid_q, valid_d;
  logic         ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q   <= '0;
      value_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      bcd_q   <= bcd_d;
      value_q <= value_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  // Codes 0xC..0xE fall through the digit test and leave the buffer alone.
  always_comb begin
    bcd_d   = bcd_q;
    value_d = value_q;
    count_d = count_q;
    valid_d = 1'b0;
    ovf_d   = 1'b0;
    if (key_valid_i) begin
      case (key_code_i)
        KEY_BKSP: begin
          if (count_q != 4'd0) begin
            bcd_d   = bcd_q >> 4;
            count_d = count_q - 4'd1;
          end
        end
        KEY_CLR: begin
          bcd_d   = '0;
          count_d = '0;
        end
        KEY_ENT: begin
          value_d = bcd_q;
          valid_d = 1'b1;
          bcd_d   = '0;
          count_d = '0;
        end
        default: begin
          if (key_code_i <= 4'd9) begin
            if (count_q < FULL) begin
              bcd_d   = (bcd_q << 4) | W'(key_code_i);
              count_d = count_q + 4'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign entry_bcd   = bcd_q;
  assign entry_value = value_q;
  assign entry_count = count_q;
  assign entry_valid = valid_q;
  assign overflow    = ovf_q;

endmodule

// File: rtl/keypad_entry_decoder.sv
// Keypad decode front end: captures one scanner event per press, validates and
// decodes it, then waits for a debounced release before accepting another.
module keypad_entry_decoder
  import keypad_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned RELEASE_CYCLES = 16
) (
  input logic                   clk,
  input logic                   rst,
  keypad_entry_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [7:0]       cap_q, cap_d;
  logic [CNT_W-1:0] rel_cnt_q, rel_cnt_d;
  logic             key_valid_q, key_valid_d;
  logic             key_err_q, key_err_d;
  logic [3:0]       key_code_q, key_code_d;

  logic             legal_c;
  logic [3:0]       code_c;
  logic             buf_valid_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cap_q       <= '0;
      rel_cnt_q   <= '0;
      key_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
      key_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      rel_cnt_q   <= rel_cnt_d;
      key_valid_q <= key_valid_d;
      key_err_q   <= key_err_d;
      key_code_q  <= key_code_d;
    end
  end

  assign legal_c = onehot_n_ok(cap_q[7:4]) && onehot_n_ok(cap_q[3:0]);
  assign code_c  = {onehot_n_to_idx(cap_q[7:4]), onehot_n_to_idx(cap_q[3:0])};

  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    rel_cnt_d   = rel_cnt_q;
    key_valid_d = 1'b0;
    key_err_d   = 1'b0;
    key_code_d  = key_code_q;
    buf_valid_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.pressed_in) begin
          cap_d   = bus.enc_in;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (legal_c) begin
          key_valid_d = 1'b1;
          key_code_d  = code_c;
          buf_valid_c = 1'b1;
        end else begin
          key_err_d = 1'b1;
        end
        rel_cnt_d = '0;
        state_d   = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        // Any high sample restarts the release window, absorbing bounce.
        if (bus.pressed_in) begin
          rel_cnt_d = '0;
        end else if (rel_cnt_q == REL_LAST) begin
          rel_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          rel_cnt_d = rel_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.key_valid = key_valid_q;
  assign bus.key_err   = key_err_q;
  assign bus.key_code  = key_code_q;

  keypad_entry_buffer #(
    .DIGITS (DIGITS)
  ) u_buffer (
    .clk         (clk),
    .rst_n       (rst),
    .key_valid_i (buf_valid_c),
    .key_code_i  (code_c),
    .entry_bcd   (bus.entry_bcd),
    .entry_count (bus.entry_count),
    .entry_valid (bus.entry_valid),
    .entry_value (bus.entry_value),
    .overflow    (bus.overflow)
  );

endmodule

// File: tb/tb_keypad_entry_decoder.sv
// Directed bench for keypad_entry_decoder: key table with hand-computed
// buffer state, plus hold, bounce and mid-press reset sequences.
module tb_keypad_entry_decoder;
  import keypad_pkg::*;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned RC     = 16;

  logic clk;
  logic rst;

  keypad_entry_decoder_if #(.DIGITS(DIGITS)) bus ();

  keypad_entry_decoder #(
    .DIGITS         (DIGITS),
    .RELEASE_CYCLES (RC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int kv_cnt = 0;
  int ke_cnt = 0;

  // Event counters sampled mid-cycle so each one-cycle pulse counts once.
  always @(negedge clk) begin
    if (bus.key_valid) kv_cnt <= kv_cnt + 1;
    if (bus.key_err)   ke_cnt <= ke_cnt + 1;
  end

  typedef struct {
    logic [7:0]  enc;
    logic [3:0]  code;
    logic        err;
    logic [15:0] bcd;
    logic [3:0]  cnt;
    logic        ev;
    logic [15:0] val;
    logic        ovf;
  } vec_t;

  vec_t vecs[17];

  function automatic logic [7:0] rc(input int r, input int c);
    logic [3:0] one;
    logic [3:0] rn;
    logic [3:0] cn;
    one = 4'b0001;
    rn  = ~(one << r);
    cn  = ~(one << c);
    return {rn, cn};
  endfunction

  function automatic vec_t mk(input logic [7:0] e, input logic [3:0] c, input logic er,
                              input logic [15:0] b, input logic [3:0] n, input logic ev,
                              input logic [15:0] v, input logic ov);
    vec_t t;
    t.enc = e; t.code = c; t.err = er; t.bcd = b;
    t.cnt = n; t.ev = ev; t.val = v; t.ovf = ov;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive a press and stop at the cycle where the decode result is visible.
  task automatic press_to_result(input logic [7:0] enc);
    @(negedge clk);
    bus.enc_in     = enc;
    bus.pressed_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_key(input int hold);
    repeat (hold) @(negedge clk);
    bus.pressed_in = 1'b0;
    repeat (RC + 4) @(negedge clk);
  endtask

  int base;

  initial begin
    rst            = 1'b0;
    bus.enc_in     = 8'h00;
    bus.pressed_in = 1'b0;

    vecs[0]  = mk(rc(0,1), 4'h1, 1'b0, 16'h0001, 4'd2, 1'b0, 16'h0000, 1'b0);
    vecs[1]  = mk(rc(0,2), 4'h2, 1'b0, 16'h0012, 4'd3, 1'b0, 16'h0000, 1'b0);
    vecs[2]  = mk(rc(1,1), 4'h5, 1'b0, 16'h0125, 4'd4, 1'b0, 16'h0000, 1'b0);
    vecs[3]  = mk(rc(3,3), 4'hF, 1'b0, 16'h0000, 4'd0, 1'b1, 16'h0125, 1'b0);
    vecs[4]  = mk(rc(0,1), 4'h1, 1'b0, 16'h0001, 4'd1, 1'b0, 16'h0125, 1'b0);
    vecs[5]  = mk(rc(0,2), 4'h2, 1'b0, 16'h0012, 4'd2, 1'b0, 16'h0125, 1'b0);
    vecs[6]  = mk(rc(0,3), 4'h3, 1'b0, 16'h0123, 4'd3, 1'b0, 16'h0125, 1'b0);
    vecs[7]  = mk(rc(1,0), 4'h4, 1'b0, 16'h1234, 4'd4, 1'b0, 16'h0125, 1'b0);
    vecs[8]  = mk(rc(1,1), 4'h5, 1'b0, 16'h1234, 4'd4, 1'b0, 16'h0125, 1'b1);
    vecs[9]  = mk(rc(2,2), 4'hA, 1'b0, 16'h0123, 4'd3, 1'b0, 16'h0125, 1'b0);
    vecs[10] = mk(8'hCE,   4'hA, 1'b1, 16'h0123, 4'd3, 1'b0, 16'h0125, 1'b0);
    vecs[11] = mk(8'hEF,   4'hA, 1'b1, 16'h0123, 4'd3, 1'b0, 16'h0125, 1'b0);
    vecs[12] = mk(rc(2,3), 4'hB, 1'b0, 16'h0000, 4'd0, 1'b0, 16'h0125, 1'b0);
    vecs[13] = mk(rc(2,2), 4'hA, 1'b0, 16'h0000, 4'd0, 1'b0, 16'h0125, 1'b0);
    vecs[14] = mk(rc(3,3), 4'hF, 1'b0, 16'h0000, 4'd0, 1'b1, 16'h0000, 1'b0);
    vecs[15] = mk(rc(3,0), 4'hC, 1'b0, 16'h0000, 4'd0, 1'b0, 16'h0000, 1'b0);
    vecs[16] = mk(rc(2,1), 4'h9, 1'b0, 16'h0009, 4'd1, 1'b0, 16'h0000, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_key_valid", 32'(bus.key_valid), 32'd0);
    chk("rst_key_code",  32'(bus.key_code),  32'd0);
    chk("rst_entry_bcd", 32'(bus.entry_bcd), 32'd0);
    chk("rst_count",     32'(bus.entry_count), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Key 0 held 40 cycles; a code change while held must be ignored
    base = kv_cnt;
    press_to_result(8'b1110_1110);
    chk("hold_key_valid", 32'(bus.key_valid), 32'd1);
    chk("hold_key_code",  32'(bus.key_code),  32'd0);
    chk("hold_count",     32'(bus.entry_count), 32'd1);
    repeat (10) @(negedge clk);
    bus.enc_in = rc(1,1);
    release_key(28);
    chk("hold_events",    32'(kv_cnt - base), 32'd1);
    chk("hold_code_kept", 32'(bus.key_code),  32'd0);
    chk("hold_count_end", 32'(bus.entry_count), 32'd1);

    // Key table
    for (int i = 0; i < 17; i++) begin
      base = kv_cnt + ke_cnt;
      press_to_result(vecs[i].enc);
      chk($sformatf("v%0d_key_valid", i), 32'(bus.key_valid), 32'(!vecs[i].err));
      chk($sformatf("v%0d_key_err", i),   32'(bus.key_err),   32'(vecs[i].err));
      chk($sformatf("v%0d_key_code", i),  32'(bus.key_code),  32'(vecs[i].code));
      chk($sformatf("v%0d_bcd", i),       32'(bus.entry_bcd), 32'(vecs[i].bcd));
      chk($sformatf("v%0d_count", i),     32'(bus.entry_count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_entry_valid", i), 32'(bus.entry_valid), 32'(vecs[i].ev));
      chk($sformatf("v%0d_entry_value", i), 32'(bus.entry_value), 32'(vecs[i].val));
      chk($sformatf("v%0d_overflow", i),  32'(bus.overflow), 32'(vecs[i].ovf));
      release_key(3);
      chk($sformatf("v%0d_events", i), 32'(kv_cnt + ke_cnt - base), 32'd1);
    end

    // Bounce shorter than the release window yields a single event
    base = kv_cnt;
    @(negedge clk);
    bus.enc_in     = rc(0,1);
    bus.pressed_in = 1'b1;
    repeat (10) @(negedge clk);
    bus.pressed_in = 1'b0;
    repeat (5) @(negedge clk);
    bus.pressed_in = 1'b1;
    repeat (10) @(negedge clk);
    bus.pressed_in = 1'b0;
    repeat (20) @(negedge clk);
    repeat (RC + 4) @(negedge clk);
    chk("bounce_events", 32'(kv_cnt - base), 32'd1);
    chk("bounce_bcd",    32'(bus.entry_bcd), 32'h0091);
    chk("bounce_count",  32'(bus.entry_count), 32'd2);

    // Reset while waiting for release with three digits held
    press_to_result(rc(0,2));
    chk("pre_rst_bcd",   32'(bus.entry_bcd), 32'h0912);
    chk("pre_rst_count", 32'(bus.entry_count), 32'd3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_bcd",   32'(bus.entry_bcd),   32'd0);
    chk("midrst_count", 32'(bus.entry_count), 32'd0);
    chk("midrst_code",  32'(bus.key_code),    32'd0);
    chk("midrst_value", 32'(bus.entry_value), 32'd0);
    chk("midrst_flags", 32'({bus.key_valid, bus.key_err, bus.entry_valid, bus.overflow}), 32'd0);
    bus.enc_in = rc(1,1);
    repeat (2) @(negedge clk);
    base = kv_cnt;
    rst  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("postrst_key_valid", 32'(bus.key_valid), 32'd1);
    chk("postrst_code",      32'(bus.key_code),  32'd5);
    chk("postrst_bcd",       32'(bus.entry_bcd), 32'h0005);
    chk("postrst_count",     32'(bus.entry_count), 32'd1);
    release_key(5);
    chk("postrst_events", 32'(kv_cnt - base), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
